// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and pointer-width helper for the I2C FIFO bridge (optional macro I2C_FIFO_ERR_EN)
package i2c_pkg;

  // Default byte width of the TX/RX FIFOs
  localparam int I2C_DATA_W = 8;

  // Default number of entries per FIFO (power of two, at least 2)
  localparam int I2C_DEPTH  = 8;

  // Pointer/level width: one extra bit over the address so full and empty differ
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FWFT FIFO with level/flags and optional sticky errors (macro I2C_FIFO_ERR_EN)
module sync_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_W = I2C_DATA_W,
  parameter int DEPTH  = I2C_DEPTH
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_rd,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [ptr_w(DEPTH)-1:0]  o_level
`ifdef I2C_FIFO_ERR_EN
  ,
  output logic                     o_ovf_err,
  output logic                     o_udf_err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;

  // Flags from the registered pointers: same lap means empty, opposite lap at same slot means full
  always_comb begin
    w_empty = (r_wp == r_rp);
    w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  end

  // Accept a push when there is room, or when a pop frees a slot on the same edge;
  // a pop is accepted only when something is stored, so empty push+pop keeps just the push
  always_comb begin
    w_push = i_wr && (!w_full || i_rd);
    w_pop  = i_rd && !w_empty;
  end

  // Pointer update: reset and flush rewind both pointers, flush beating any strobe
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wp <= '0;
      r_rp <= '0;
    end else if (i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
    end
  end

  // Storage write: contents are never cleared, only the pointers move
  always_ff @(posedge PCLK) begin
    if (w_push && !i_flush) r_mem[r_wp[AW-1:0]] <= i_wdata;
  end

  // Head entry shown directly from storage so a new byte appears one cycle after its push
  always_comb begin
    o_rdata = r_mem[r_rp[AW-1:0]];
    o_full  = w_full;
    o_empty = w_empty;
    o_level = r_wp - r_rp;
  end

`ifdef I2C_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // Sticky error capture: dropped push sets overflow, ignored pop sets underflow; only flush/reset clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (i_flush) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (i_wr && w_full && !i_rd) r_ovf <= 1'b1;
      if (i_rd && w_empty)         r_udf <= 1'b1;
    end
  end

  // Expose the sticky flags
  always_comb begin
    o_ovf_err = r_ovf;
    o_udf_err = r_udf;
  end
`endif

endmodule

// File: rtl/i2c_fifo_bridge.sv
// rtl/i2c_fifo_bridge.sv - TX/RX byte FIFOs between the APB side and the I2C core (optional macro I2C_FIFO_ERR_EN)
module i2c_fifo_bridge
  import i2c_pkg::*;
#(
  parameter int DATA_W = I2C_DATA_W,
  parameter int DEPTH  = I2C_DEPTH
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     flush,
  input  logic                     tx_wr,
  input  logic [DATA_W-1:0]        tx_wdata,
  input  logic                     tx_rd,
  output logic [DATA_W-1:0]        tx_rdata,
  output logic                     tx_full,
  output logic                     tx_empty,
  output logic [ptr_w(DEPTH)-1:0]  tx_level,
  input  logic                     rx_wr,
  input  logic [DATA_W-1:0]        rx_wdata,
  input  logic                     rx_rd,
  output logic [DATA_W-1:0]        rx_rdata,
  output logic                     rx_full,
  output logic                     rx_empty,
  output logic [ptr_w(DEPTH)-1:0]  rx_level
`ifdef I2C_FIFO_ERR_EN
  ,
  output logic                     ovf_err,
  output logic                     udf_err
`endif
);

`ifdef I2C_FIFO_ERR_EN
  logic w_tx_ovf;
  logic w_tx_udf;
  logic w_rx_ovf;
  logic w_rx_udf;
`endif

  // APB pushes, I2C core pops
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_tx_fifo (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_flush   (flush),
    .i_wr      (tx_wr),
    .i_wdata   (tx_wdata),
    .i_rd      (tx_rd),
    .o_rdata   (tx_rdata),
    .o_full    (tx_full),
    .o_empty   (tx_empty),
    .o_level   (tx_level)
`ifdef I2C_FIFO_ERR_EN
    ,
    .o_ovf_err (w_tx_ovf),
    .o_udf_err (w_tx_udf)
`endif
  );

  // I2C core pushes received bytes, APB pops
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_rx_fifo (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .i_flush   (flush),
    .i_wr      (rx_wr),
    .i_wdata   (rx_wdata),
    .i_rd      (rx_rd),
    .o_rdata   (rx_rdata),
    .o_full    (rx_full),
    .o_empty   (rx_empty),
    .o_level   (rx_level)
`ifdef I2C_FIFO_ERR_EN
    ,
    .o_ovf_err (w_rx_ovf),
    .o_udf_err (w_rx_udf)
`endif
  );

`ifdef I2C_FIFO_ERR_EN
  // One overflow and one underflow flag cover both directions
  always_comb begin
    ovf_err = w_tx_ovf | w_rx_ovf;
    udf_err = w_tx_udf | w_rx_udf;
  end
`endif

endmodule

// File: tb/tb_i2c_fifo_bridge.sv
// tb/tb_i2c_fifo_bridge.sv - directed self-checking bench for i2c_fifo_bridge (optional macro I2C_FIFO_ERR_EN)
module tb_i2c_fifo_bridge;

  logic       PCLK;
  logic       PRESETn;
  logic       flush;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       tx_rd;
  logic [7:0] tx_rdata;
  logic       tx_full;
  logic       tx_empty;
  logic [3:0] tx_level;
  logic       rx_wr;
  logic [7:0] rx_wdata;
  logic       rx_rd;
  logic [7:0] rx_rdata;
  logic       rx_full;
  logic       rx_empty;
  logic [3:0] rx_level;
`ifdef I2C_FIFO_ERR_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  i2c_fifo_bridge #(.DATA_W(8), .DEPTH(8)) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .flush    (flush),
    .tx_wr    (tx_wr),
    .tx_wdata (tx_wdata),
    .tx_rd    (tx_rd),
    .tx_rdata (tx_rdata),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .tx_level (tx_level),
    .rx_wr    (rx_wr),
    .rx_wdata (rx_wdata),
    .rx_rd    (rx_rd),
    .rx_rdata (rx_rdata),
    .rx_full  (rx_full),
    .rx_empty (rx_empty),
    .rx_level (rx_level)
`ifdef I2C_FIFO_ERR_EN
    ,
    .ovf_err  (ovf_err),
    .udf_err  (udf_err)
`endif
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
    tx_wr = 1'b0;
    tx_rd = 1'b0;
    rx_wr = 1'b0;
    rx_rd = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    #12;
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_tx_empty got=%b exp=1", tx_empty); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
    n_cmp++; if (tx_full !== 1'b0) begin n_bad++; $display("FAIL reset_tx_full got=%b exp=0", tx_full); end
    n_cmp++; if (rx_full !== 1'b0) begin n_bad++; $display("FAIL reset_rx_full got=%b exp=0", rx_full); end
    n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL reset_tx_level got=%0d exp=0", tx_level); end
    n_cmp++; if (rx_level !== 4'd0) begin n_bad++; $display("FAIL reset_rx_level got=%0d exp=0", rx_level); end
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    n_cmp++; if (udf_err !== 1'b0) begin n_bad++; $display("FAIL reset_udf got=%b exp=0", udf_err); end
`endif
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
  endtask

  task automatic test_push_single();
    tx_wr = 1'b1; tx_wdata = 8'hA5;
    tick();
    n_cmp++; if (tx_rdata !== 8'hA5) begin n_bad++; $display("FAIL single_rdata got=%h exp=a5", tx_rdata); end
    n_cmp++; if (tx_level !== 4'd1) begin n_bad++; $display("FAIL single_level got=%0d exp=1", tx_level); end
    n_cmp++; if (tx_empty !== 1'b0) begin n_bad++; $display("FAIL single_empty got=%b exp=0", tx_empty); end
    n_cmp++; if (rx_level !== 4'd0) begin n_bad++; $display("FAIL single_rx_indep got=%0d exp=0", rx_level); end
  endtask

  task automatic test_tx_full();
    logic [7:0] held;
    do_flush();
    for (int i = 0; i < 8; i++) begin
      tx_wr = 1'b1; tx_wdata = 8'(i);
      tick();
    end
    n_cmp++; if (tx_full !== 1'b1) begin n_bad++; $display("FAIL full_flag got=%b exp=1", tx_full); end
    n_cmp++; if (tx_level !== 4'd8) begin n_bad++; $display("FAIL full_level got=%0d exp=8", tx_level); end
    tx_wr = 1'b1; tx_wdata = 8'hFF;
    tick();
    n_cmp++; if (tx_level !== 4'd8) begin n_bad++; $display("FAIL ovf_level got=%0d exp=8", tx_level); end
    n_cmp++; if (tx_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full got=%b exp=1", tx_full); end
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_err got=%b exp=1", ovf_err); end
    n_cmp++; if (udf_err !== 1'b0) begin n_bad++; $display("FAIL ovf_udf got=%b exp=0", udf_err); end
`endif
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (tx_rdata !== 8'(i)) begin n_bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, tx_rdata, 8'(i)); end
      tx_rd = 1'b1;
      tick();
    end
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty got=%b exp=1", tx_empty); end
    held = tx_rdata;
    tx_rd = 1'b1;
    tick();
    n_cmp++; if (tx_rdata !== held) begin n_bad++; $display("FAIL udf_hold got=%h exp=%h", tx_rdata, held); end
    n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL udf_level got=%0d exp=0", tx_level); end
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (udf_err !== 1'b1) begin n_bad++; $display("FAIL tx_udf_err got=%b exp=1", udf_err); end
`endif
  endtask

  task automatic test_rx_full_simul();
    do_flush();
    for (int i = 0; i < 8; i++) begin
      rx_wr = 1'b1; rx_wdata = 8'h10 + 8'(i);
      tick();
    end
    rx_wr = 1'b1; rx_wdata = 8'h3C; rx_rd = 1'b1;
    tick();
    n_cmp++; if (rx_level !== 4'd8) begin n_bad++; $display("FAIL rxsim_level got=%0d exp=8", rx_level); end
    n_cmp++; if (rx_full !== 1'b1) begin n_bad++; $display("FAIL rxsim_full got=%b exp=1", rx_full); end
    n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL rxsim_tx_indep got=%0d exp=0", tx_level); end
    for (int i = 1; i < 9; i++) begin
      logic [7:0] exp_b;
      exp_b = (i == 8) ? 8'h3C : 8'h10 + 8'(i);
      n_cmp++; if (rx_rdata !== exp_b) begin n_bad++; $display("FAIL rxsim_data[%0d] got=%h exp=%h", i, rx_rdata, exp_b); end
      rx_rd = 1'b1;
      tick();
    end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL rxsim_empty got=%b exp=1", rx_empty); end
  endtask

  task automatic test_rx_underflow();
    do_flush();
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (udf_err !== 1'b0) begin n_bad++; $display("FAIL flush_clr_udf got=%b exp=0", udf_err); end
`endif
    rx_rd = 1'b1;
    tick();
    n_cmp++; if (rx_level !== 4'd0) begin n_bad++; $display("FAIL rxudf_level got=%0d exp=0", rx_level); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL rxudf_empty got=%b exp=1", rx_empty); end
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (udf_err !== 1'b1) begin n_bad++; $display("FAIL rxudf_err got=%b exp=1", udf_err); end
`endif
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1; tx_wdata = 8'h20 + 8'(i);
      tick();
    end
    n_cmp++; if (tx_level !== 4'd3) begin n_bad++; $display("FAIL preflush_level got=%0d exp=3", tx_level); end
    flush = 1'b1; tx_wr = 1'b1; tx_wdata = 8'h99;
    tick();
    n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL flush_level got=%0d exp=0", tx_level); end
    n_cmp++; if (tx_empty !== 1'b1) begin n_bad++; $display("FAIL flush_empty got=%b exp=1", tx_empty); end
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL flush_ovf got=%b exp=0", ovf_err); end
    n_cmp++; if (udf_err !== 1'b0) begin n_bad++; $display("FAIL flush_udf got=%b exp=0", udf_err); end
`endif
  endtask

  task automatic test_empty_simul();
    do_flush();
    tx_wr = 1'b1; tx_wdata = 8'h6E; tx_rd = 1'b1;
    tick();
    n_cmp++; if (tx_level !== 4'd1) begin n_bad++; $display("FAIL esim_level got=%0d exp=1", tx_level); end
    n_cmp++; if (tx_rdata !== 8'h6E) begin n_bad++; $display("FAIL esim_data got=%h exp=6e", tx_rdata); end
`ifdef I2C_FIFO_ERR_EN
    n_cmp++; if (ovf_err !== 1'b0) begin n_bad++; $display("FAIL esim_ovf got=%b exp=0", ovf_err); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    do_flush();
    for (int i = 0; i < 4; i++) begin
      tx_wr = 1'b1; tx_wdata = 8'h40 + 8'(i);
      q.push_back(8'h40 + 8'(i));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (tx_rdata !== q[0]) begin n_bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, tx_rdata, q[0]); end
      tx_wr = 1'b1; tx_wdata = 8'h50 + 8'(i); tx_rd = 1'b1;
      q.push_back(8'h50 + 8'(i));
      void'(q.pop_front());
      tick();
      n_cmp++; if (tx_level !== 4'd4) begin n_bad++; $display("FAIL b2b_level[%0d] got=%0d exp=4", i, tx_level); end
    end
  endtask

  task automatic test_async_reset();
    rx_wr = 1'b1; rx_wdata = 8'h77;
    tick();
    rx_wr = 1'b1; rx_wdata = 8'h78;
    tick();
    #2;
    PRESETn = 1'b0;
    #1;
    n_cmp++; if (rx_level !== 4'd0) begin n_bad++; $display("FAIL arst_rx_level got=%0d exp=0", rx_level); end
    n_cmp++; if (tx_level !== 4'd0) begin n_bad++; $display("FAIL arst_tx_level got=%0d exp=0", tx_level); end
    n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL arst_rx_empty got=%b exp=1", rx_empty); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();
  endtask

  initial begin
    PRESETn = 1'b1;
    flush = 1'b0;
    tx_wr = 1'b0; tx_rd = 1'b0; tx_wdata = '0;
    rx_wr = 1'b0; rx_rd = 1'b0; rx_wdata = '0;
    test_reset();
    test_push_single();
    test_tx_full();
    test_rx_full_simul();
    test_rx_underflow();
    test_flush();
    test_empty_simul();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_fifo_bridge.md
I2C_FIFO_BRIDGE -- requirements
Module: i2c_fifo_bridge

Interface
REQ-001 Parameter DATA_W, default 8: byte width of both FIFOs.
REQ-002 Parameter DEPTH, default 8: entries per FIFO; SHALL be a power of two, at least 2.
REQ-003 PCLK  in  1  clock; all state updates on its rising edge.
REQ-004 PRESETn  in  1  reset, asynchronous, active-low.
REQ-005 tx_wr  in  1  push strobe from the APB side (TX FIFO write).
REQ-006 tx_wdata  in  DATA_W  byte to transmit.
REQ-007 tx_rd  in  1  pop strobe from the I2C core (TX FIFO read).
REQ-008 tx_rdata  out  DATA_W  TX head byte, first-word-fall-through.
REQ-009 tx_full / tx_empty  out  1 each  TX status flags.
REQ-010 tx_level  out  log2(DEPTH)+1  TX occupancy.
REQ-011 rx_wr  in  1  push strobe from the I2C core (received byte).
REQ-012 rx_wdata  in  DATA_W  received byte.
REQ-013 rx_rd  in  1  pop strobe from the APB side.
REQ-014 rx_rdata  out  DATA_W  RX head byte, first-word-fall-through.
REQ-015 rx_full / rx_empty  out  1 each  RX status flags.
REQ-016 rx_level  out  log2(DEPTH)+1  RX occupancy.
REQ-017 flush  in  1  synchronous clear of both FIFOs.
REQ-018 ovf_err / udf_err  out  1 each  sticky error flags; present only under I2C_FIFO_ERR_EN.

Function
REQ-019 Each FIFO SHALL use read/write pointers of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full = MSBs differ and LSBs are equal; empty = pointers are equal.
REQ-020 A push SHALL be accepted on the clock edge where its wr strobe is 1 and the FIFO is not full; the byte is visible on rdata on the next cycle if the FIFO was empty.
REQ-021 A pop SHALL be accepted on the clock edge where its rd strobe is 1 and the FIFO is not empty; rdata SHALL show the next entry on the following cycle.
REQ-022 A push to a full FIFO without a simultaneous pop SHALL be dropped, with no state change.
REQ-023 A pop from an empty FIFO SHALL be ignored, and rdata SHALL hold its value.
REQ-024 Push and pop together on a full FIFO: both SHALL be accepted; level stays DEPTH; full stays 1.
REQ-025 Push and pop together on an empty FIFO: only the push SHALL be accepted; level becomes 1.
REQ-026 Push and pop together in any other state: both accepted; level unchanged.
REQ-027 flush SHALL reset both FIFOs' pointers to 0 on the next edge and SHALL override any push or pop in the same cycle; stored data is not cleared.
REQ-028 level, full and empty SHALL be registered-pointer derived, with zero additional latency beyond the pointer update.
REQ-029 The TX and RX FIFOs SHALL be fully independent; no strobe on one affects the other.

Reset
REQ-030 While PRESETn=0: all pointers 0; tx_empty=rx_empty=1; tx_full=rx_full=0; levels 0; ovf_err=udf_err=0.
REQ-031 Asserting PRESETn mid-operation SHALL discard all queued bytes immediately; rdata is undefined until the first push after reset.

Configuration
REQ-032 Macro I2C_FIFO_ERR_EN defined: ovf_err SHALL set on any push dropped per REQ-022 and udf_err on any pop ignored per REQ-023; both SHALL clear only on reset or flush.
REQ-033 Macro I2C_FIFO_ERR_EN undefined: the ovf_err and udf_err ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package i2c_pkg SHALL hold DATA_W, the default DEPTH, and the pointer-width constant function, shared with the APB interface and I2C core.
REQ-035 A single sub-module sync_fifo (one FIFO with level/flags/error logic) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-036 Reset, then push 0xA5 into TX -> next cycle tx_rdata=0xA5, tx_level=1, tx_empty=0.
REQ-037 Push 8 bytes 0x00..0x07 into TX, then a 9th byte 0xFF -> tx_full=1, level=8, 0xFF dropped, ovf_err=1 (macro on); pops then return 0x00..0x07 in order.
REQ-038 RX full with 8 bytes, then rx_wr and rx_rd in the same cycle with 0x3C -> level stays 8; 0x3C is returned after the 7 remaining older bytes.
REQ-039 Empty RX, rx_rd=1 -> level 0, rx_empty=1, udf_err=1 (macro on); with the macro off, the port is absent.
REQ-040 Push 3 bytes to TX, then assert flush together with tx_wr=1 -> tx_level=0, tx_empty=1, ovf_err=0.
REQ-041 Push and pop continuously for 20 cycles with DEPTH=8 -> pointers wrap correctly; data is returned in order with no loss; level stays constant.
